// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe sequencer: turns mouse packets into board moves, tracks turn and detects win/draw.
// Optional feature: define TTT_TURN_TIMEOUT_EN to forfeit a turn after TIMEOUT_CYCLES idle cycles.
module ttt_game_ctrl #(
  parameter int X0             = 64,
  parameter int Y0             = 32,
  parameter int CELL_W         = 64,
  parameter int TIMEOUT_CYCLES = 150_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  xm,
  input  logic [8:0]  ym,
  input  logic [2:0]  btnm,
  input  logic        m_done_tick,
  output logic [17:0] board,
  output logic        turn,
  output logic [1:0]  game_state,
  output logic        winner,
  output logic [7:0]  win_line,
  output logic        move_tick
);

  typedef enum logic [1:0] {S_PLAY, S_CHECK, S_OVER} state_t;

  localparam logic [1:0] GS_PLAY = 2'b00;
  localparam logic [1:0] GS_WIN  = 2'b01;
  localparam logic [1:0] GS_DRAW = 2'b10;

  localparam logic [9:0] XB0 = 10'(X0);
  localparam logic [9:0] XB1 = 10'(X0 + CELL_W);
  localparam logic [9:0] XB2 = 10'(X0 + 2 * CELL_W);
  localparam logic [9:0] XB3 = 10'(X0 + 3 * CELL_W);
  localparam logic [9:0] YB0 = 10'(Y0);
  localparam logic [9:0] YB1 = 10'(Y0 + CELL_W);
  localparam logic [9:0] YB2 = 10'(Y0 + 2 * CELL_W);
  localparam logic [9:0] YB3 = 10'(Y0 + 3 * CELL_W);

  state_t      state;
  logic [1:0]  btn_prev;
  logic        left_click, right_click;
  logic [9:0]  x10, y10;
  logic [1:0]  col, row;
  logic        col_ok, row_ok, cell_ok, cell_empty;
  logic [3:0]  cell_idx;
  logic [4:0]  bit_lo;
  logic [1:0]  mover_code;
  logic [7:0]  lines_now;
  logic        board_full;
  logic        unused_mid;

  assign unused_mid  = btnm[2];
  assign left_click  = m_done_tick & btnm[0] & ~btn_prev[0];
  assign right_click = m_done_tick & btnm[1] & ~btn_prev[1];

  // Widen to 10 bits so board edges near 511 never wrap in the comparators.
  assign x10 = {1'b0, xm};
  assign y10 = {1'b0, ym};

  always_comb begin
    col    = 2'd0;
    col_ok = 1'b1;
    if      (x10 >= XB0 && x10 < XB1) col = 2'd0;
    else if (x10 >= XB1 && x10 < XB2) col = 2'd1;
    else if (x10 >= XB2 && x10 < XB3) col = 2'd2;
    else                              col_ok = 1'b0;
  end

  always_comb begin
    row    = 2'd0;
    row_ok = 1'b1;
    if      (y10 >= YB0 && y10 < YB1) row = 2'd0;
    else if (y10 >= YB1 && y10 < YB2) row = 2'd1;
    else if (y10 >= YB2 && y10 < YB3) row = 2'd2;
    else                              row_ok = 1'b0;
  end

  assign cell_ok    = col_ok & row_ok;
  assign cell_idx   = ({2'b00, row} * 4'd3) + {2'b00, col};
  assign bit_lo     = {cell_idx, 1'b0};
  assign cell_empty = (board[bit_lo +: 2] == 2'b00);
  assign mover_code = turn ? 2'b10 : 2'b01;

  always_comb begin
    logic [8:0] m;
    m = '0;
    board_full = 1'b1;
    for (int k = 0; k < 9; k++) begin
      m[k] = (board[2*k +: 2] == mover_code);
      if (board[2*k +: 2] == 2'b00) board_full = 1'b0;
    end
    lines_now[0] = m[0] & m[1] & m[2];
    lines_now[1] = m[3] & m[4] & m[5];
    lines_now[2] = m[6] & m[7] & m[8];
    lines_now[3] = m[0] & m[3] & m[6];
    lines_now[4] = m[1] & m[4] & m[7];
    lines_now[5] = m[2] & m[5] & m[8];
    lines_now[6] = m[0] & m[4] & m[8];
    lines_now[7] = m[2] & m[4] & m[6];
  end

`ifdef TTT_TURN_TIMEOUT_EN
  logic [31:0] timer;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_PLAY;
      board      <= '0;
      turn       <= 1'b0;
      game_state <= GS_PLAY;
      winner     <= 1'b0;
      win_line   <= '0;
      move_tick  <= 1'b0;
      btn_prev   <= '0;
`ifdef TTT_TURN_TIMEOUT_EN
      timer      <= '0;
`endif
    end else begin
      move_tick <= 1'b0;
      if (m_done_tick) btn_prev <= btnm[1:0];
`ifdef TTT_TURN_TIMEOUT_EN
      timer <= '0;
`endif
      // Restart overrides everything, including a pending CHECK result.
      if (right_click) begin
        state      <= S_PLAY;
        board      <= '0;
        turn       <= 1'b0;
        game_state <= GS_PLAY;
        winner     <= 1'b0;
        win_line   <= '0;
      end else begin
        case (state)
          S_PLAY: begin
            if (left_click && cell_ok && cell_empty) begin
              board[bit_lo +: 2] <= mover_code;
              move_tick          <= 1'b1;
              state              <= S_CHECK;
            end
`ifdef TTT_TURN_TIMEOUT_EN
            else if (timer == 32'(TIMEOUT_CYCLES - 1)) begin
              turn <= ~turn;
            end else begin
              timer <= timer + 32'd1;
            end
`endif
          end
          S_CHECK: begin
            if (|lines_now) begin
              game_state <= GS_WIN;
              winner     <= turn;
              win_line   <= lines_now;
              state      <= S_OVER;
            end else if (board_full) begin
              game_state <= GS_DRAW;
              state      <= S_OVER;
            end else begin
              turn  <= ~turn;
              state <= S_PLAY;
            end
          end
          default: state <= S_OVER;
        endcase
      end
    end
  end

endmodule
